pipe_stage_reg: RTL

Parametrised, handshaked pipeline stage register: the generalised successor to the fixed-field inter-stage latches between the decode, execute, memory and writeback stages of the CPU pipeline. It carries an opaque data payload and a control payload from an upstream stage to a downstream stage with valid/ready flow control, downstream back-pressure (stall), synchronous flush (bubble insertion) and a saturating stall-cycle counter. Every inter-stage boundary in the core instantiates one copy with its own widths.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_stage_reg_if.sv | 32 +++
 rtl/pipe_skid_slot.sv | 38 +++
 rtl/pipe_stage_reg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and width defaults for the handshaked pipeline stage register.
// The skid-buffer state encoding is only used when PIPE_SKID_EN is defined.
package pipe_pkg;

  localparam int DW_DEF   = 160;
  localparam int CW_DEF   = 24;
  localparam int CNTW_DEF = 16;

  // Value every control bit takes in a bubble, so RegW/MemW/Branch/Jump can never leak through.
  localparam logic FLUSH_CTRL_BIT = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between an upstream stage, the stage register and its consumer.
// The slave modport is the stage register; master is the side that drives it.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int CNTW = CNTW_DEF
) ();

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [CW-1:0]   in_ctrl;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic [CNTW-1:0] stall_cnt;

  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

endinterface

// File: rtl/pipe_skid_slot.sv
// One held entry (data + control) with synchronous clear and load; clear wins and zeroes both.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic [DW-1:0] d_in,
  input  logic [CW-1:0] c_in,
  output logic [DW-1:0] d_out,
  output logic [CW-1:0] c_out
);

  logic [DW-1:0] data_r;
  logic [CW-1:0] ctrl_r;

  // Entry storage: reset and clear both produce an all-zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= {DW{1'b0}};
      ctrl_r <= {CW{FLUSH_CTRL_BIT}};
    end else if (clear) begin
      data_r <= {DW{1'b0}};
      ctrl_r <= {CW{FLUSH_CTRL_BIT}};
    end else if (load) begin
      data_r <= d_in;
      ctrl_r <= c_in;
    end
  end

  assign d_out = data_r;
  assign c_out = ctrl_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush, back-pressure and a saturating stall counter.
// Define PIPE_SKID_EN to add a second (skid) entry and make in_ready a registered output.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int CW   = CW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stage_reg_if.slave    bus
);

  logic            in_ready_s;
  logic            out_valid_s;
  logic            in_fire_s;
  logic            out_fire_s;
  logic            stall_s;
  logic            main_load_s;
  logic [DW-1:0]   main_d_s;
  logic [CW-1:0]   main_c_s;
  logic [DW-1:0]   main_q_d_s;
  logic [CW-1:0]   main_q_c_s;
  logic [CNTW-1:0] stall_cnt_r;

  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign out_fire_s = out_valid_s && bus.out_ready;
  assign stall_s    = out_valid_s && !bus.out_ready && !bus.flush;

`ifdef PIPE_SKID_EN
  pipe_state_e   state_r;
  pipe_state_e   state_nxt_s;
  logic          ready_r;
  logic          valid_r;
  logic          skid_load_s;
  logic          main_from_skid_s;
  logic [DW-1:0] skid_q_d_s;
  logic [CW-1:0] skid_q_c_s;

  // State plus ready/valid flops decoded from the next state, so both handshake outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != ST_TWO);
      valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Next-state and slot steering; a stalled second beat parks in the skid slot.
  always_comb begin
    state_nxt_s      = state_r;
    main_load_s      = 1'b0;
    skid_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    if (bus.flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else if (in_fire_s) begin
            state_nxt_s = ST_TWO;
            skid_load_s = 1'b1;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_nxt_s      = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready_s  = ready_r && !bus.flush;
  assign out_valid_s = valid_r;
  assign main_d_s    = main_from_skid_s ? skid_q_d_s : bus.in_data;
  assign main_c_s    = main_from_skid_s ? skid_q_c_s : bus.in_ctrl;

  pipe_skid_slot #(.DW(DW), .CW(CW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.flush),
    .load  (skid_load_s),
    .d_in  (bus.in_data),
    .c_in  (bus.in_ctrl),
    .d_out (skid_q_d_s),
    .c_out (skid_q_c_s)
  );
`else
  logic valid_r;

  // Occupancy of the single main entry; flush has priority over both handshakes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
    end else if (bus.flush) begin
      valid_r <= 1'b0;
    end else if (in_fire_s) begin
      valid_r <= 1'b1;
    end else if (out_fire_s) begin
      valid_r <= 1'b0;
    end
  end

  assign in_ready_s  = !bus.flush && (!valid_r || bus.out_ready);
  assign out_valid_s = valid_r;
  assign main_load_s = in_fire_s;
  assign main_d_s    = bus.in_data;
  assign main_c_s    = bus.in_ctrl;
`endif

  pipe_skid_slot #(.DW(DW), .CW(CW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.flush),
    .load  (main_load_s),
    .d_in  (main_d_s),
    .c_in  (main_c_s),
    .d_out (main_q_d_s),
    .c_out (main_q_c_s)
  );

  // Saturating count of cycles the consumer held off a valid entry; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNTW{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNTW{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = main_q_d_s;
  assign bus.out_ctrl  = main_q_c_s;
  assign bus.stall_cnt = stall_cnt_r;

endmodule
